// File: rtl/parking_pkg.sv
// Shared types, default sizes and helpers for the parking-lot RFID blocks.
package parking_pkg;

  localparam int TAG_W_DEF          = 16;
  localparam int NUM_TAGS_DEF       = 8;
  localparam int TIMEOUT_CYCLES_DEF = 1000;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    LOOKUP,
    RESPOND
  } rfid_state_t;

  // Zero-extension does not change parity, so any tag up to 64 bits fits.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/rfid_tag_table.sv
// Whitelist of NUM_TAGS tag entries, each with a valid bit.
// Provides one write port and a combinational scan-read port.
module rfid_tag_table #(
  parameter int TAG_W    = 16,
  parameter int NUM_TAGS = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_TAGS)-1:0] wr_idx,
  input  logic [TAG_W-1:0]            wr_tag,
  input  logic                        wr_valid,
  input  logic [$clog2(NUM_TAGS)-1:0] rd_idx,
  output logic [TAG_W-1:0]            rd_tag,
  output logic                        rd_valid
);

  logic [TAG_W-1:0]    tag_q [NUM_TAGS];
  logic [NUM_TAGS-1:0] valid_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
    end
  end

  // NOTE: tag storage has no reset; a cleared valid bit makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_tag;
    end
  end

  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/rfid_tag_validator.sv
// Responder side of the RFID handshake: collects a serial tag frame and checks it against a whitelist.
// Optional build macro RFID_PARITY_CHECK_EN rejects frames with a bad even-parity bit before lookup.
module rfid_tag_validator
  import parking_pkg::*;
#(
  parameter int TAG_W          = TAG_W_DEF,
  parameter int NUM_TAGS       = NUM_TAGS_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        ActivateRFID,
  input  logic                        rfid_bit,
  input  logic                        rfid_bit_valid,
  input  logic                        tbl_wr_en,
  input  logic [$clog2(NUM_TAGS)-1:0] tbl_wr_idx,
  input  logic [TAG_W-1:0]            tbl_wr_tag,
  input  logic                        tbl_wr_valid,
  output logic                        ValidTag,
  output logic                        ValidationFail,
  output logic [TAG_W-1:0]            tag_id,
  output logic                        busy
);

  localparam int IDX_W = $clog2(NUM_TAGS);
  localparam int BIT_W = $clog2(TAG_W + 2);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BIT_W-1:0] FRAME_BITS = BIT_W'(TAG_W + 1);
  localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_TAGS - 1);

  rfid_state_t      state_q, state_d;
  logic [TAG_W:0]   shift_q, shift_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0] tag_id_q, tag_id_d;
  logic             valid_tag_q, valid_tag_d;
  logic             fail_q, fail_d;

  logic [TAG_W-1:0] rd_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] frame_tag;
  logic [TO_W-1:0]  to_inc;
  logic             tbl_hit;

  assign busy           = (state_q != IDLE);
  assign ValidTag       = valid_tag_q;
  assign ValidationFail = fail_q;
  assign tag_id         = tag_id_q;

  rfid_tag_table #(
    .TAG_W    (TAG_W),
    .NUM_TAGS (NUM_TAGS)
  ) u_table (
    .clk      (clk),
    .resetn   (resetn),
    .wr_en    (tbl_wr_en && !busy),
    .wr_idx   (tbl_wr_idx),
    .wr_tag   (tbl_wr_tag),
    .wr_valid (tbl_wr_valid),
    .rd_idx   (idx_q),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid)
  );

  assign frame_tag = shift_q[TAG_W:1];
  assign tbl_hit   = rd_valid && (rd_tag == tag_id_q);
  assign to_inc    = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + 1'b1;

  // NOTE: every variable gets its default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    idx_d       = idx_q;
    tag_id_d    = tag_id_q;
    valid_tag_d = valid_tag_q;
    fail_d      = fail_q;

    unique case (state_q)
      IDLE: begin
        if (ActivateRFID) begin
          state_d   = COLLECT;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
        end
      end
      COLLECT: begin
        if (!ActivateRFID) begin
          state_d = IDLE;
        end else if (bit_cnt_q == FRAME_BITS) begin
          tag_id_d = frame_tag;
          idx_d    = '0;
`ifdef RFID_PARITY_CHECK_EN
          if (shift_q[0] != even_parity(64'(frame_tag))) begin
            state_d = RESPOND;
            fail_d  = 1'b1;
          end else begin
            state_d = LOOKUP;
          end
`else
          state_d = LOOKUP;
`endif
        end else if (rfid_bit_valid) begin
          shift_d   = {shift_q[TAG_W-1:0], rfid_bit};
          bit_cnt_d = bit_cnt_q + 1'b1;
          to_cnt_d  = '0;
        end else begin
          to_cnt_d = to_inc;
          if (to_inc == TO_MAX) begin
            state_d = RESPOND;
            fail_d  = 1'b1;
          end
        end
      end
      LOOKUP: begin
        if (!ActivateRFID) begin
          state_d = IDLE;
        end else if (tbl_hit) begin
          state_d     = RESPOND;
          valid_tag_d = 1'b1;
        end else if (idx_q == LAST_IDX) begin
          state_d = RESPOND;
          fail_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RESPOND: begin
        if (!ActivateRFID) begin
          state_d     = IDLE;
          valid_tag_d = 1'b0;
          fail_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      idx_q       <= '0;
      tag_id_q    <= '0;
      valid_tag_q <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      idx_q       <= idx_d;
      tag_id_q    <= tag_id_d;
      valid_tag_q <= valid_tag_d;
      fail_q      <= fail_d;
    end
  end

endmodule

// File: tb/tb_rfid_tag_validator.sv
// Directed bench for rfid_tag_validator with default parameters (16-bit tags, 8 entries, 1000-cycle timeout).
module tb_rfid_tag_validator;

  localparam int TAG_W    = 16;
  localparam int NUM_TAGS = 8;
  localparam int TIMEOUT  = 1000;

  logic             clk = 1'b0;
  logic             resetn;
  logic             ActivateRFID;
  logic             rfid_bit;
  logic             rfid_bit_valid;
  logic             tbl_wr_en;
  logic [2:0]       tbl_wr_idx;
  logic [TAG_W-1:0] tbl_wr_tag;
  logic             tbl_wr_valid;
  logic             ValidTag;
  logic             ValidationFail;
  logic [TAG_W-1:0] tag_id;
  logic             busy;

  int nvec = 0;
  int nerr = 0;

  rfid_tag_validator #(
    .TAG_W          (TAG_W),
    .NUM_TAGS       (NUM_TAGS),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ActivateRFID   (ActivateRFID),
    .rfid_bit       (rfid_bit),
    .rfid_bit_valid (rfid_bit_valid),
    .tbl_wr_en      (tbl_wr_en),
    .tbl_wr_idx     (tbl_wr_idx),
    .tbl_wr_tag     (tbl_wr_tag),
    .tbl_wr_valid   (tbl_wr_valid),
    .ValidTag       (ValidTag),
    .ValidationFail (ValidationFail),
    .tag_id         (tag_id),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int idx, input logic [TAG_W-1:0] tag, input logic vld);
    tbl_wr_en    = 1'b1;
    tbl_wr_idx   = 3'(idx);
    tbl_wr_tag   = tag;
    tbl_wr_valid = vld;
    tick();
    tbl_wr_en    = 1'b0;
  endtask

  // A valid bit presented in the activating cycle must be ignored.
  task automatic start();
    ActivateRFID   = 1'b1;
    rfid_bit       = 1'b1;
    rfid_bit_valid = 1'b1;
    tick();
    rfid_bit_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    rfid_bit       = b;
    rfid_bit_valid = 1'b1;
    tick();
    rfid_bit_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [TAG_W-1:0] tag, input logic par);
    for (int i = TAG_W - 1; i >= 0; i--) send_bit(tag[i]);
    send_bit(par);
  endtask

  // Response must appear exactly lat cycles after the last sampled bit.
  task automatic wait_resp(input string name, input int lat, input logic pass);
    repeat (lat - 1) tick();
    check({name, " early"}, {30'd0, ValidTag, ValidationFail}, 32'd0);
    tick();
    check({name, " resp"}, {30'd0, ValidTag, ValidationFail}, pass ? 32'd2 : 32'd1);
  endtask

  task automatic release_req(input string name);
    ActivateRFID = 1'b0;
    tick();
    check({name, " cleared"}, {29'd0, ValidTag, ValidationFail, busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn         = 1'b0;
    ActivateRFID   = 1'b0;
    rfid_bit       = 1'b0;
    rfid_bit_valid = 1'b0;
    tbl_wr_en      = 1'b0;
    tbl_wr_idx     = '0;
    tbl_wr_tag     = '0;
    tbl_wr_valid   = 1'b0;
    tick();
    tick();
    check("reset outputs", {29'd0, ValidTag, ValidationFail, busy}, 32'd0);
    check("reset tag_id", 32'(tag_id), 32'd0);
    resetn = 1'b1;

    // Hit on entry 2, held while requested, cleared on release.
    write_entry(2, 16'hA5C3, 1'b1);
    start();
    check("s1 busy", 32'(busy), 32'd1);
    send_frame(16'hA5C3, 1'b0);
    wait_resp("s1", 4, 1'b1);
    check("s1 tag_id", 32'(tag_id), 32'hA5C3);
    tick();
    tick();
    check("s1 hold", {30'd0, ValidTag, ValidationFail}, 32'd2);
    release_req("s1");

    // Tag absent from the table: full scan then fail.
    start();
    send_frame(16'h1234, 1'b1);
    wait_resp("s2", NUM_TAGS + 1, 1'b0);
    check("s2 tag_id", 32'(tag_id), 32'h1234);
    release_req("s2");

    // Five bits then silence: timeout.
    start();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    wait_resp("s3 timeout", TIMEOUT, 1'b0);
    release_req("s3");

    // Wrong parity bit.
    start();
    send_frame(16'hA5C3, 1'b1);
`ifdef RFID_PARITY_CHECK_EN
    wait_resp("s4 parity", 1, 1'b0);
`else
    wait_resp("s4 parity", 4, 1'b1);
`endif
    release_req("s4");

    // Abort after 8 bits, with a table write attempted while busy.
    start();
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    tbl_wr_en    = 1'b1;
    tbl_wr_idx   = 3'd2;
    tbl_wr_tag   = 16'hBEEF;
    tbl_wr_valid = 1'b1;
    send_bit(1'b1);
    tbl_wr_en    = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    release_req("s5 abort");
    start();
    send_frame(16'hA5C3, 1'b0);
    wait_resp("s5 table kept", 4, 1'b1);
    release_req("s5b");

    // Boundary entries: first and last index, then delete.
    write_entry(0, 16'h1234, 1'b1);
    start();
    send_frame(16'h1234, 1'b1);
    wait_resp("idx0 hit", 2, 1'b1);
    release_req("idx0");

    write_entry(7, 16'h0F0F, 1'b1);
    start();
    send_frame(16'h0F0F, 1'b0);
    wait_resp("idx7 hit", NUM_TAGS + 1, 1'b1);
    release_req("idx7");

    write_entry(0, 16'h1234, 1'b0);
    start();
    send_frame(16'h1234, 1'b1);
    wait_resp("deleted", NUM_TAGS + 1, 1'b0);
    release_req("deleted");

    // Reset while responding clears outputs and the whitelist.
    start();
    send_frame(16'hA5C3, 1'b0);
    wait_resp("s6 pre", 4, 1'b1);
    resetn       = 1'b0;
    ActivateRFID = 1'b0;
    tick();
    check("s6 reset outputs", {29'd0, ValidTag, ValidationFail, busy}, 32'd0);
    check("s6 reset tag_id", 32'(tag_id), 32'd0);
    resetn = 1'b1;
    start();
    send_frame(16'hA5C3, 1'b0);
    wait_resp("s6 replay", NUM_TAGS + 1, 1'b0);
    release_req("s6");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
